// File: rtl/zfsoc_onchip_memory_dp.sv
// Dual-port byte-enabled on-chip RAM with two Avalon-MM slaves (s1, s2).
// Reads are pipelined to readdatavalid; same-address dual writes are merged and reported.
module zfsoc_onchip_memory_dp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter bit OUTREG     = 1'b0,
    parameter     INIT_FILE  = "zfsoc_onchip_memory_dp.hex"
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clken,
    input  logic                    reset_req,

    input  logic [ADDR_WIDTH-1:0]   s1_address,
    input  logic                    s1_chipselect,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
    input  logic [DATA_WIDTH-1:0]   s1_writedata,
    output logic [DATA_WIDTH-1:0]   s1_readdata,
    output logic                    s1_readdatavalid,

    input  logic [ADDR_WIDTH-1:0]   s2_address,
    input  logic                    s2_chipselect,
    input  logic                    s2_read,
    input  logic                    s2_write,
    input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
    input  logic [DATA_WIDTH-1:0]   s2_writedata,
    output logic [DATA_WIDTH-1:0]   s2_readdata,
    output logic                    s2_readdatavalid,

    output logic                    collision
);

    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int DEPTH     = 1 << ADDR_WIDTH;

    // Handshake: there is no waitrequest, so every strobe seen while en=1 is
    // accepted that cycle. readdatavalid is a one-cycle qualifier; readdata is
    // meaningful only while it is high. Words held during a stall (en=0) are
    // masked and presented exactly once when en returns.

    logic                  en;
    logic [ADDR_WIDTH-1:0] addr  [2];
    logic [NUM_LANES-1:0]  be    [2];
    logic [DATA_WIDTH-1:0] wdata [2];
    logic [1:0]            wr_go;
    logic [1:0]            rd_go;

    assign en = clken & ~reset_req;

    assign addr[0]  = s1_address;
    assign addr[1]  = s2_address;
    assign be[0]    = s1_byteenable;
    assign be[1]    = s2_byteenable;
    assign wdata[0] = s1_writedata;
    assign wdata[1] = s2_writedata;

    // A write on a port suppresses a read strobed on the same port in that cycle.
    assign wr_go[0] = s1_chipselect & s1_write & en;
    assign wr_go[1] = s2_chipselect & s2_write & en;
    assign rd_go[0] = s1_chipselect & s1_read & ~s1_write & en;
    assign rd_go[1] = s2_chipselect & s2_read & ~s2_write & en;

    // Storage is never reset; contents survive reset_n.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // s2 lanes are written first so a lane also enabled on s1 at the same
    // address finishes with s1 data.
    always_ff @(posedge clk) begin
        for (int l = 0; l < NUM_LANES; l++) begin
            if (wr_go[1] && be[1][l]) begin
                mem[addr[1]][l*8 +: 8] <= wdata[1][l*8 +: 8];
            end
            if (wr_go[0] && be[0][l]) begin
                mem[addr[0]][l*8 +: 8] <= wdata[0][l*8 +: 8];
            end
        end
    end

    // First read stage samples the array before this edge's writes land,
    // giving old data on mixed-port read-during-write.
    logic [1:0]            st1_valid;
    logic [DATA_WIDTH-1:0] st1_data [2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st1_valid   <= '0;
            st1_data[0] <= '0;
            st1_data[1] <= '0;
        end else if (en) begin
            st1_valid <= rd_go;
            for (int p = 0; p < 2; p++) begin
                if (rd_go[p]) begin
                    st1_data[p] <= mem[addr[p]];
                end
            end
        end
    end

    logic [1:0]            out_valid;
    logic [DATA_WIDTH-1:0] out_data [2];

    generate
        if (OUTREG) begin : g_outreg
            logic [1:0]            st2_valid;
            logic [DATA_WIDTH-1:0] st2_data [2];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    st2_valid   <= '0;
                    st2_data[0] <= '0;
                    st2_data[1] <= '0;
                end else if (en) begin
                    st2_valid <= st1_valid;
                    for (int p = 0; p < 2; p++) begin
                        if (st1_valid[p]) begin
                            st2_data[p] <= st1_data[p];
                        end
                    end
                end
            end

            assign out_valid   = st2_valid;
            assign out_data[0] = st2_data[0];
            assign out_data[1] = st2_data[1];
        end else begin : g_direct
            assign out_valid   = st1_valid;
            assign out_data[0] = st1_data[0];
            assign out_data[1] = st1_data[1];
        end
    endgenerate

    assign s1_readdata      = out_data[0];
    assign s2_readdata      = out_data[1];
    assign s1_readdatavalid = out_valid[0] & en;
    assign s2_readdatavalid = out_valid[1] & en;

    // Recomputed every edge so the pulse lasts exactly one cycle even across stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            collision <= 1'b0;
        end else begin
            collision <= wr_go[0] & wr_go[1] & (addr[0] == addr[1]);
        end
    end

endmodule

// File: tb/tb_zfsoc_onchip_memory_dp.sv
// Bench for zfsoc_onchip_memory_dp: directed scenarios plus random traffic,
// checked against an enabled-cycle-counting reference model.
module tb_zfsoc_onchip_memory_dp;

    localparam int DW     = 32;
    localparam int AW     = 4;
    localparam int NB     = DW / 8;
    localparam bit OUTREG = 1'b0;
    localparam int LAT    = 1 + int'(OUTREG);

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          clken = 1'b1;
    logic          reset_req = 1'b0;
    logic [AW-1:0] s1_address = '0, s2_address = '0;
    logic          s1_chipselect = 1'b0, s2_chipselect = 1'b0;
    logic          s1_read = 1'b0, s2_read = 1'b0;
    logic          s1_write = 1'b0, s2_write = 1'b0;
    logic [NB-1:0] s1_byteenable = '0, s2_byteenable = '0;
    logic [DW-1:0] s1_writedata = '0, s2_writedata = '0;
    logic [DW-1:0] s1_readdata, s2_readdata;
    logic          s1_readdatavalid, s2_readdatavalid;
    logic          collision;

    zfsoc_onchip_memory_dp #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .OUTREG    (OUTREG),
        .INIT_FILE ("zfsoc_onchip_memory_dp.hex")
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .clken           (clken),
        .reset_req       (reset_req),
        .s1_address      (s1_address),
        .s1_chipselect   (s1_chipselect),
        .s1_read         (s1_read),
        .s1_write        (s1_write),
        .s1_byteenable   (s1_byteenable),
        .s1_writedata    (s1_writedata),
        .s1_readdata     (s1_readdata),
        .s1_readdatavalid(s1_readdatavalid),
        .s2_address      (s2_address),
        .s2_chipselect   (s2_chipselect),
        .s2_read         (s2_read),
        .s2_write        (s2_write),
        .s2_byteenable   (s2_byteenable),
        .s2_writedata    (s2_writedata),
        .s2_readdata     (s2_readdata),
        .s2_readdatavalid(s2_readdatavalid),
        .collision       (collision)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- port views for the model ----------------
    logic [1:0]    t_cs, t_rd, t_wr, t_rdv;
    logic [AW-1:0] t_addr [2];
    logic [NB-1:0] t_be   [2];
    logic [DW-1:0] t_wd   [2];
    logic [DW-1:0] t_rdd  [2];

    assign t_cs      = {s2_chipselect, s1_chipselect};
    assign t_rd      = {s2_read, s1_read};
    assign t_wr      = {s2_write, s1_write};
    assign t_rdv     = {s2_readdatavalid, s1_readdatavalid};
    assign t_addr[0] = s1_address;
    assign t_addr[1] = s2_address;
    assign t_be[0]   = s1_byteenable;
    assign t_be[1]   = s2_byteenable;
    assign t_wd[0]   = s1_writedata;
    assign t_wd[1]   = s2_writedata;
    assign t_rdd[0]  = s1_readdata;
    assign t_rdd[1]  = s2_readdata;

    // ---------------- scoreboard state ----------------
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            coll_cnt = 0;
    logic          coll_exp = 1'b0;
    logic [DW-1:0] mdl [1 << AW];
    logic [DW-1:0] exp_q [2][$];
    int            cnt_q [2][$];
    logic [DW-1:0] got_q [2][$];
    int            got_cyc [2];

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] got_at(input int p, input int i);
        if (i < got_q[p].size()) return got_q[p][i];
        return 32'hBAD0_0BAD;
    endfunction

    // Runs at the falling edge: checks outputs, then folds this cycle's
    // inputs into the model. A read is returned in the LAT-th enabled
    // cycle after it was accepted.
    task automatic monitor();
        logic          en_now;
        logic          exp_v;
        logic [DW-1:0] d;
        en_now = clken & ~reset_req;
        if (!reset_n) begin
            for (int p = 0; p < 2; p++) begin
                check("rst_rdv", {31'd0, t_rdv[p]}, 32'd0);
                check("rst_rdata", t_rdd[p], 32'd0);
                exp_q[p].delete();
                cnt_q[p].delete();
            end
            check("rst_collision", {31'd0, collision}, 32'd0);
            coll_exp = 1'b0;
            return;
        end
        check("collision", {31'd0, collision}, {31'd0, coll_exp});
        if (collision) coll_cnt++;
        for (int p = 0; p < 2; p++) begin
            exp_v = 1'b0;
            if (en_now) begin
                for (int i = 0; i < cnt_q[p].size(); i++) cnt_q[p][i] = cnt_q[p][i] - 1;
                if (cnt_q[p].size() > 0 && cnt_q[p][0] == 0) exp_v = 1'b1;
            end
            check(p == 0 ? "s1_rdv" : "s2_rdv", {31'd0, t_rdv[p]}, {31'd0, exp_v});
            if (exp_v) begin
                d = exp_q[p].pop_front();
                void'(cnt_q[p].pop_front());
                check(p == 0 ? "s1_rdata" : "s2_rdata", t_rdd[p], d);
                got_q[p].push_back(t_rdd[p]);
                got_cyc[p] = cyc;
            end
        end
        coll_exp = en_now && t_cs[0] && t_wr[0] && t_cs[1] && t_wr[1] && (t_addr[0] == t_addr[1]);
        if (en_now) begin
            for (int p = 0; p < 2; p++) begin
                if (t_cs[p] && t_rd[p] && !t_wr[p]) begin
                    exp_q[p].push_back(mdl[t_addr[p]]);
                    cnt_q[p].push_back(LAT);
                end
            end
            for (int l = 0; l < NB; l++) begin
                if (t_cs[0] && t_wr[0] && t_be[0][l])
                    mdl[t_addr[0]][l*8 +: 8] = t_wd[0][l*8 +: 8];
                if (t_cs[1] && t_wr[1] && t_be[1][l] &&
                    !(t_cs[0] && t_wr[0] && t_be[0][l] && t_addr[0] == t_addr[1]))
                    mdl[t_addr[1]][l*8 +: 8] = t_wd[1][l*8 +: 8];
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input int p, input logic cs, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [NB-1:0] b, input logic [DW-1:0] d);
        if (p == 0) begin
            s1_chipselect = cs; s1_read = rd; s1_write = wr;
            s1_address = a; s1_byteenable = b; s1_writedata = d;
        end else begin
            s2_chipselect = cs; s2_read = rd; s2_write = wr;
            s2_address = a; s2_byteenable = b; s2_writedata = d;
        end
    endtask

    task automatic wr_op(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] b);
        drive(p, 1'b1, 1'b0, 1'b1, a, b, d);
    endtask

    task automatic rd_op(input int p, input logic [AW-1:0] a);
        drive(p, 1'b1, 1'b1, 1'b0, a, '0, '0);
    endtask

    task automatic idle();
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic clear_log();
        got_q[0].delete();
        got_q[1].delete();
        got_cyc[0] = -1;
        got_cyc[1] = -1;
    endtask

    task automatic settle(input int n);
        idle();
        repeat (n) cycle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int issue;
        for (int i = 0; i < (1 << AW); i++) mdl[i] = '0;
        clear_log();
        #2 reset_n = 1'b0;
        repeat (3) cycle();
        reset_n = 1'b1;

        // Latency: write then read on s1.
        clear_log();
        wr_op(0, 4'd5, 32'hDEADBEEF, 4'hF); cycle();
        rd_op(0, 4'd5); issue = cyc; cycle();
        settle(4);
        check("lat_count", got_q[0].size(), 1);
        check("lat_cycles", got_cyc[0] - issue, LAT);
        check("lat_data", got_at(0, 0), 32'hDEADBEEF);

        // Byte lanes on s2.
        clear_log();
        wr_op(0, 4'd7, 32'h11223344, 4'hF); cycle();
        wr_op(1, 4'd7, 32'hAABBCCDD, 4'h5); idle(); wr_op(1, 4'd7, 32'hAABBCCDD, 4'h5); cycle();
        idle(); rd_op(1, 4'd7); cycle();
        settle(4);
        check("lanes_data", got_at(1, 0), 32'h11BB33DD);

        // Mixed-port read-during-write.
        clear_log();
        idle(); wr_op(0, 4'd9, 32'h0, 4'hF); cycle();
        wr_op(0, 4'd9, 32'h12345678, 4'hF); rd_op(1, 4'd9); cycle();
        idle(); rd_op(1, 4'd9); cycle();
        settle(4);
        check("rdw_count", got_q[1].size(), 2);
        check("rdw_old", got_at(1, 0), 32'h0);
        check("rdw_new", got_at(1, 1), 32'h12345678);

        // Same-address collisions.
        clear_log();
        coll_cnt = 0;
        wr_op(0, 4'd3, 32'hFFFF0000, 4'hC); wr_op(1, 4'd3, 32'h0000FFFF, 4'h3); cycle();
        idle(); rd_op(0, 4'd3); cycle();
        settle(4);
        check("coll_pulses_1", coll_cnt, 1);
        check("coll_merge", got_at(0, 0), 32'hFFFFFFFF);
        wr_op(0, 4'd3, 32'hA5A5A5A5, 4'hF); wr_op(1, 4'd3, 32'h5A5A5A5A, 4'hF); cycle();
        idle(); rd_op(0, 4'd3); cycle();
        settle(4);
        check("coll_pulses_2", coll_cnt, 2);
        check("coll_s1_wins", got_at(0, 1), 32'hA5A5A5A5);

        // Stall via clken, then via reset_req.
        wr_op(0, 4'd1, 32'h0000_0101, 4'hF); wr_op(1, 4'd2, 32'h0000_0202, 4'hF); cycle();
        idle(); wr_op(0, 4'd3, 32'h0000_0303, 4'hF); cycle();
        for (int mode = 0; mode < 2; mode++) begin
            clear_log();
            idle(); rd_op(0, 4'd1); cycle();
            rd_op(0, 4'd2); cycle();
            idle();
            if (mode == 0) clken = 1'b0; else reset_req = 1'b1;
            repeat (3) cycle();
            clken = 1'b1; reset_req = 1'b0;
            rd_op(0, 4'd3); cycle();
            settle(4);
            check(mode == 0 ? "stall_clken_count" : "stall_rreq_count", got_q[0].size(), 3);
            check("stall_word0", got_at(0, 0), 32'h0000_0101);
            check("stall_word1", got_at(0, 1), 32'h0000_0202);
            check("stall_word2", got_at(0, 2), 32'h0000_0303);
        end

        // Asynchronous reset with reads in flight on both ports.
        clear_log();
        rd_op(0, 4'd7); rd_op(1, 4'd9); cycle();
        idle();
        #2 reset_n = 1'b0;
        #1;
        check("arst_s1_rdv", {31'd0, s1_readdatavalid}, 32'd0);
        check("arst_s2_rdv", {31'd0, s2_readdatavalid}, 32'd0);
        check("arst_s1_rdata", s1_readdata, 32'd0);
        check("arst_s2_rdata", s2_readdata, 32'd0);
        check("arst_collision", {31'd0, collision}, 32'd0);
        repeat (2) cycle();
        #2 reset_n = 1'b1;
        settle(4);
        check("arst_no_valid", got_q[0].size() + got_q[1].size(), 0);
        rd_op(0, 4'd7); rd_op(1, 4'd9); cycle();
        settle(4);
        check("arst_keep7", got_at(0, 0), 32'h11BB33DD);
        check("arst_keep9", got_at(1, 0), 32'h12345678);

        // Random traffic: preload every word, then mixed strobes and stalls.
        for (int i = 0; i < (1 << AW); i += 2) begin
            wr_op(0, AW'(i), $urandom, 4'hF);
            wr_op(1, AW'(i + 1), $urandom, 4'hF);
            cycle();
        end
        for (int n = 0; n < 2000; n++) begin
            for (int p = 0; p < 2; p++) begin
                drive(p, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 2) == 0, AW'($urandom_range(0, (1 << AW) - 1)),
                      NB'($urandom_range(0, (1 << NB) - 1)), $urandom);
            end
            clken = $urandom_range(0, 7) != 0;
            reset_req = $urandom_range(0, 15) == 0;
            cycle();
        end
        clken = 1'b1; reset_req = 1'b0;
        settle(LAT + 3);
        check("drain_s1", exp_q[0].size(), 0);
        check("drain_s2", exp_q[1].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
